// File: rtl/rv32i_inst_encoder_pkg.sv
// Shared RV32I opcode/funct3 constants plus the encoder's instruction-format
// enum, FSM state enum and the canonical NOP word.
package rv32i_inst_encoder_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;

   // ADDI x0,x0,0 -- substituted for anything that cannot be encoded
   localparam logic [31:0] NOP_INST = 32'h00000013;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_SHIFT,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } inst_fmt_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      DONE
   } enc_state_t;

   // Map an opcode (and funct3, to split out immediate shifts) to its format
   function automatic inst_fmt_t inst_format(input logic [6:0] opcode,
                                             input logic [2:0] funct3);
      inst_fmt_t fmt;
      case (opcode)
         OPC_RTYPE:  fmt = FMT_R;
         OPC_ITYPE:  fmt = (funct3 == F3_SLL || funct3 == F3_SRL_SRA) ? FMT_SHIFT : FMT_I;
         OPC_LOAD,
         OPC_JALR,
         OPC_SYSTEM,
         OPC_FENCE:  fmt = FMT_I;
         OPC_STORE:  fmt = FMT_S;
         OPC_BRANCH: fmt = FMT_B;
         OPC_LUI,
         OPC_AUIPC:  fmt = FMT_U;
         OPC_JAL:    fmt = FMT_J;
         default:    fmt = FMT_BAD;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/rv32i_enc_fifo.sv
// Small synchronous FIFO decoupling the encoder from the memory write port.
// DEPTH must be a power of two, at least 2. Read data is the current head.
module rv32i_enc_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full      = (count_q == DEPTH_V);
   assign empty     = (count_q == '0);
   assign occupancy = count_q;
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign rdata     = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; push+pop together leaves occupancy as is
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Data storage needs no reset; occupancy decides what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: packs decoded field bundles into 32-bit words
// and writes a programmed number of them to consecutive IMEM addresses.
// Optional build macro RV32I_ENC_RANGE_CHECK_EN: out-of-range immediates are
// replaced by a NOP and raise o_err; without it they are silently truncated.
module rv32i_inst_encoder
   import rv32i_inst_encoder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int COUNT_WIDTH = 10,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic [ADDR_WIDTH-1:0]  i_base_addr,
   input  logic [COUNT_WIDTH-1:0] i_count,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [6:0]             i_opcode,
   input  logic [4:0]             i_rd_addr,
   input  logic [4:0]             i_rs1_addr,
   input  logic [4:0]             i_rs2_addr,
   input  logic [2:0]             i_funct3,
   input  logic [6:0]             i_funct7,
   input  logic [31:0]            i_imm,
   output logic                   o_mem_we,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   output logic [31:0]            o_mem_wdata,
   input  logic                   i_mem_ready,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0]       DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP  = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0]  ADDR_ALIGN = ~ADDR_WIDTH'(3);

   enc_state_t             state_q;
   enc_state_t             state_d;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] accepted_q;
   logic [COUNT_WIDTH-1:0] written_q;
   logic                   err_q;

   inst_fmt_t              fmt;
   logic [31:0]            enc_word;
   logic                   enc_bad;
   logic                   accept;
   logic                   write_done;
   logic                   fifo_push;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [31:0]            fifo_rdata;
   logic [CNT_W-1:0]       fifo_count;

   assign fmt        = inst_format(i_opcode, i_funct3);
   assign o_ready    = (state_q == LOAD) && (fifo_count < DEPTH_CNT) && (accepted_q < count_q);
   assign accept     = i_valid && o_ready;
   assign fifo_push  = accept && !fifo_full;
   assign o_mem_we   = !fifo_empty;
   assign write_done = o_mem_we && i_mem_ready;
   assign o_mem_addr = addr_q;
   assign o_mem_wdata = fifo_empty ? 32'h0 : fifo_rdata;
   assign o_busy     = (state_q != IDLE);
   assign o_done     = (state_q == DONE);
   assign o_err      = err_q;

`ifdef RV32I_ENC_RANGE_CHECK_EN
   logic imm_illegal;

   // Flag immediates that do not fit the selected format's field
   always_comb begin
      imm_illegal = 1'b0;
      case (fmt)
         FMT_I,
         FMT_S:     imm_illegal = !((&i_imm[31:11]) || !(|i_imm[31:11]));
         FMT_SHIFT: imm_illegal = |i_imm[31:5];
         FMT_B:     imm_illegal = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
         FMT_J:     imm_illegal = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
         FMT_U:     imm_illegal = |i_imm[11:0];
         default:   imm_illegal = 1'b0;
      endcase
   end
`endif

   // Pack the field bundle into an instruction word; unencodable input gives a NOP
   always_comb begin
      enc_word = NOP_INST;
      enc_bad  = 1'b0;
      case (fmt)
         FMT_R:     enc_word = {i_funct7, i_rs2_addr, i_rs1_addr, i_funct3, i_rd_addr, i_opcode};
         FMT_I:     enc_word = {i_imm[11:0], i_rs1_addr, i_funct3, i_rd_addr, i_opcode};
         FMT_SHIFT: enc_word = {i_funct7, i_imm[4:0], i_rs1_addr, i_funct3, i_rd_addr, i_opcode};
         FMT_S:     enc_word = {i_imm[11:5], i_rs2_addr, i_rs1_addr, i_funct3, i_imm[4:0], i_opcode};
         FMT_B:     enc_word = {i_imm[12], i_imm[10:5], i_rs2_addr, i_rs1_addr, i_funct3,
                                i_imm[4:1], i_imm[11], i_opcode};
         FMT_U:     enc_word = {i_imm[31:12], i_rd_addr, i_opcode};
         FMT_J:     enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd_addr, i_opcode};
         default: begin
            enc_word = NOP_INST;
            enc_bad  = 1'b1;
         end
      endcase
`ifdef RV32I_ENC_RANGE_CHECK_EN
      if (imm_illegal) begin
         enc_word = NOP_INST;
         enc_bad  = 1'b1;
      end
`endif
   end

   // Next-state logic; LOAD/DRAIN look ahead so DONE follows the last write directly
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (i_start) state_d = (i_count == '0) ? DONE : LOAD;
         end
         LOAD: begin
            if ((accepted_q == count_q) || (accept && (accepted_q + CNT_ONE == count_q)))
               state_d = DRAIN;
         end
         DRAIN: begin
            if ((written_q == count_q) || (write_done && (written_q + CNT_ONE == count_q)))
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, address, counters and sticky error; a start in IDLE re-arms everything
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         accepted_q <= '0;
         written_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && i_start) begin
            addr_q     <= i_base_addr & ADDR_ALIGN;
            count_q    <= i_count;
            accepted_q <= '0;
            written_q  <= '0;
            err_q      <= 1'b0;
         end else begin
            if (accept) accepted_q <= accepted_q + CNT_ONE;
            if (accept && enc_bad) err_q <= 1'b1;
            if (write_done) begin
               written_q <= written_q + CNT_ONE;
               addr_q    <= addr_q + ADDR_STEP;
            end
         end
      end
   end

   rv32i_enc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (fifo_push),
      .pop       (write_done),
      .wdata     (enc_word),
      .rdata     (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .occupancy (fifo_count)
   );

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Self-checking bench for rv32i_inst_encoder: directed cases plus randomized
// jobs scored against an arithmetic reference model of the RV32I formats.
module tb_rv32i_inst_encoder;

   localparam int ADDR_WIDTH  = 12;
   localparam int COUNT_WIDTH = 10;
   localparam int FIFO_DEPTH  = 2;
   localparam logic [31:0] NOP_WORD = 32'h00000013;
`ifdef RV32I_ENC_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } bundle_t;

   logic                   i_clk = 1'b0;
   logic                   i_rst = 1'b1;
   logic                   i_start = 1'b0;
   logic [ADDR_WIDTH-1:0]  i_base_addr = '0;
   logic [COUNT_WIDTH-1:0] i_count = '0;
   logic                   i_valid = 1'b0;
   logic                   o_ready;
   logic [6:0]             i_opcode = '0;
   logic [4:0]             i_rd_addr = '0;
   logic [4:0]             i_rs1_addr = '0;
   logic [4:0]             i_rs2_addr = '0;
   logic [2:0]             i_funct3 = '0;
   logic [6:0]             i_funct7 = '0;
   logic [31:0]            i_imm = '0;
   logic                   o_mem_we;
   logic [ADDR_WIDTH-1:0]  o_mem_addr;
   logic [31:0]            o_mem_wdata;
   logic                   i_mem_ready = 1'b0;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_err;

   int assertCount = 0;
   int failCount   = 0;

   bundle_t     jobQ[$];
   logic [31:0] gotAddr[$];
   logic [31:0] gotData[$];
   int          gotCycle[$];
   int          firstAccept;

   rv32i_inst_encoder #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_count     (i_count),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_opcode    (i_opcode),
      .i_rd_addr   (i_rd_addr),
      .i_rs1_addr  (i_rs1_addr),
      .i_rs2_addr  (i_rs2_addr),
      .i_funct3    (i_funct3),
      .i_funct7    (i_funct7),
      .i_imm       (i_imm),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_ready (i_mem_ready),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   // Free-running clock, 10 ns period
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference encoder: places each immediate slice by plain arithmetic
   function automatic void modelEncode(input bundle_t b, output logic [31:0] word, output bit bad);
      longint unsigned op, rd, rs1, rs2, f3, f7, u, w;
      longint          s;
      bit              legal;
      op = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; f3 = b.f3; f7 = b.f7;
      u  = b.imm;
      s  = longint'($signed(b.imm));
      legal = 1'b1;
      bad   = 1'b0;
      w     = 0;
      case (b.op)
         7'h33: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
         7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
            if (b.op == 7'h13 && (f3 == 1 || f3 == 5)) begin
               w     = (f7 << 25) | ((u % 32) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
               legal = (u < 32);
            end else begin
               w     = ((u % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
               legal = (s >= -2048) && (s <= 2047);
            end
         end
         7'h23: begin
            w     = (((u / 32) % 128) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((u % 32) << 7) | op;
            legal = (s >= -2048) && (s <= 2047);
         end
         7'h63: begin
            w     = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (rs2 << 20) | (rs1 << 15) |
                    (f3 << 12) | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7) | op;
            legal = (s >= -4096) && (s <= 4095) && (u % 2 == 0);
         end
         7'h37, 7'h17: begin
            w     = ((u / 4096) * 4096) | (rd << 7) | op;
            legal = (u % 4096 == 0);
         end
         7'h6F: begin
            w     = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21) | (((u / 2048) % 2) << 20) |
                    (((u / 4096) % 256) << 12) | (rd << 7) | op;
            legal = (s >= -1048576) && (s <= 1048575) && (u % 2 == 0);
         end
         default: bad = 1'b1;
      endcase
      if (RANGE_CHECK && !legal) bad = 1'b1;
      word = bad ? NOP_WORD : w[31:0];
   endfunction

   function automatic bundle_t mkBundle(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
      bundle_t b;
      b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = f7; b.imm = imm;
      return b;
   endfunction

   function automatic bundle_t randBundle();
      bundle_t b;
      b.rd  = 5'($urandom);
      b.rs1 = 5'($urandom);
      b.rs2 = 5'($urandom);
      b.f3  = 3'($urandom);
      b.f7  = 7'($urandom);
      if ($urandom_range(0, 29) == 0) b.op = 7'h7F;
      else begin
         case ($urandom_range(0, 10))
            0:       b.op = 7'h33;
            1:       b.op = 7'h13;
            2:       b.op = 7'h03;
            3:       b.op = 7'h67;
            4:       b.op = 7'h73;
            5:       b.op = 7'h0F;
            6:       b.op = 7'h23;
            7:       b.op = 7'h63;
            8:       b.op = 7'h37;
            9:       b.op = 7'h17;
            default: b.op = 7'h6F;
         endcase
      end
      case ($urandom_range(0, 3))
         0:       b.imm = $urandom;
         1:       b.imm = 32'(int'($urandom_range(0, 2047)) * 2 - 2048);
         2:       b.imm = $urandom & 32'hFFFFF000;
         default: b.imm = 32'($urandom_range(0, 31));
      endcase
      return b;
   endfunction

   function automatic logic [31:0] gotWord(input int i);
      return (i < gotData.size()) ? gotData[i] : 32'hDEADBEEF;
   endfunction

   function automatic int gotCyc(input int i);
      return (i < gotCycle.size()) ? gotCycle[i] : -100;
   endfunction

   // Runs one job from jobQ with random valid/ready, then scores it against the model
   task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] base, input int validPct,
                                input int readyPct, input int stall, input string name);
      int          n, idx, lastWrite, doneCycle, doneCount, expCnt;
      bit          anyBad, b;
      logic [31:0] expWord, stallWord, baseAl;
      n = jobQ.size();
      idx = 0; lastWrite = -1; doneCycle = -1; doneCount = 0; anyBad = 1'b0;
      firstAccept = -1;
      baseAl = 32'(base & 12'hFFC);
      gotAddr.delete(); gotData.delete(); gotCycle.delete();
      stallWord = NOP_WORD;
      if (n > 0) modelEncode(jobQ[0], stallWord, b);
      for (int cycle = 0; cycle < 400; cycle++) begin
         i_start     = (cycle == 0);
         i_base_addr = base;
         i_count     = COUNT_WIDTH'(n);
         i_valid     = (idx < n) && ($urandom_range(1, 100) <= validPct);
         if (idx < n) begin
            i_opcode = jobQ[idx].op; i_rd_addr = jobQ[idx].rd; i_rs1_addr = jobQ[idx].rs1;
            i_rs2_addr = jobQ[idx].rs2; i_funct3 = jobQ[idx].f3; i_funct7 = jobQ[idx].f7;
            i_imm = jobQ[idx].imm;
         end
         i_mem_ready = (cycle >= 1 && cycle <= stall) ? 1'b0 : ($urandom_range(1, 100) <= readyPct);
         @(negedge i_clk);
         if (stall > 0 && cycle >= 1 && cycle <= stall && o_mem_we) begin
            checkOutput({name, " stall addr"}, 32'(o_mem_addr), baseAl);
            checkOutput({name, " stall data"}, o_mem_wdata, stallWord);
         end
         if (stall > 0 && cycle == stall) begin
            checkOutput({name, " stall ready low"}, 32'(o_ready), 32'd0);
            checkOutput({name, " stall accepts"}, 32'(idx), 32'((n < FIFO_DEPTH) ? n : FIFO_DEPTH));
         end
         if (i_valid && o_ready) begin
            if (firstAccept < 0) firstAccept = cycle;
            idx++;
         end
         if (o_mem_we && i_mem_ready) begin
            gotAddr.push_back(32'(o_mem_addr));
            gotData.push_back(o_mem_wdata);
            gotCycle.push_back(cycle);
            lastWrite = cycle;
         end
         if (o_done) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = cycle;
         end
         @(posedge i_clk); #1;
         if (doneCycle >= 0 && cycle >= doneCycle + 2) break;
      end
      i_start = 1'b0;
      i_valid = 1'b0;
      checkOutput({name, " write count"}, 32'(gotData.size()), 32'(n));
      expCnt = (gotData.size() < n) ? gotData.size() : n;
      for (int i = 0; i < n; i++) begin
         modelEncode(jobQ[i], expWord, b);
         anyBad |= b;
         if (i < expCnt) begin
            checkOutput($sformatf("%s addr[%0d]", name, i), gotAddr[i],
                        32'((int'(baseAl) + 4 * i) % (1 << ADDR_WIDTH)));
            checkOutput($sformatf("%s data[%0d]", name, i), gotData[i], expWord);
         end
      end
      checkOutput({name, " done pulses"}, 32'(doneCount), 32'd1);
      if (n > 0) checkOutput({name, " done timing"}, 32'(doneCycle), 32'(lastWrite + 1));
      checkOutput({name, " err"}, 32'(o_err), 32'(anyBad));
      checkOutput({name, " busy after"}, 32'(o_busy), 32'd0);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, " ready"}, 32'(o_ready), 32'd0);
      checkOutput({name, " we"}, 32'(o_mem_we), 32'd0);
      checkOutput({name, " addr"}, 32'(o_mem_addr), 32'd0);
      checkOutput({name, " wdata"}, o_mem_wdata, 32'd0);
      checkOutput({name, " busy"}, 32'(o_busy), 32'd0);
      checkOutput({name, " done"}, 32'(o_done), 32'd0);
      checkOutput({name, " err"}, 32'(o_err), 32'd0);
   endtask

   // Test sequence: reset, directed cases, randomized jobs, reset mid-job
   initial begin
      repeat (3) @(posedge i_clk);
      #1;
      checkAllZero("reset");
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // ADDI x1,x0,5 single write
      jobQ.delete();
      jobQ.push_back(mkBundle(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
      applyStimulus(12'h100, 100, 100, 0, "addi");
      checkOutput("addi word", gotWord(0), 32'h00500093);
      checkOutput("addi latency", 32'(gotCyc(0)), 32'(firstAccept + 1));

      // SUB x3,x1,x2 then BEQ x1,x2,-4, back to back
      jobQ.delete();
      jobQ.push_back(mkBundle(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0));
      jobQ.push_back(mkBundle(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC));
      applyStimulus(12'h200, 100, 100, 0, "subbeq");
      checkOutput("sub word", gotWord(0), 32'h402081B3);
      checkOutput("beq word", gotWord(1), 32'hFE208EE3);
      checkOutput("subbeq back2back", 32'(gotCyc(1) - gotCyc(0)), 32'd1);

      // Illegal immediates and unknown opcode
      jobQ.delete();
      jobQ.push_back(mkBundle(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3));
      jobQ.push_back(mkBundle(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001));
      jobQ.push_back(mkBundle(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0));
      applyStimulus(12'h080, 100, 100, 0, "errs");
      checkOutput("errs beq", gotWord(0), RANGE_CHECK ? NOP_WORD : 32'h00208163);
      checkOutput("errs lui", gotWord(1), RANGE_CHECK ? NOP_WORD : 32'h123452B7);
      checkOutput("errs badop", gotWord(2), NOP_WORD);
      repeat (4) @(posedge i_clk);
      #1;
      checkOutput("err held", 32'(o_err), 32'd1);

      // JAL x1,+2048 with memory stalled five cycles
      jobQ.delete();
      repeat (3) jobQ.push_back(mkBundle(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048));
      applyStimulus(12'h400, 100, 100, 5, "jal");
      checkOutput("jal word", gotWord(0), 32'h001000EF);

      // Address wrap from 0xFFC
      jobQ.delete();
      repeat (3) jobQ.push_back(randBundle());
      applyStimulus(12'hFFC, 100, 100, 0, "wrap");
      checkOutput("wrap addr1", gotAddr.size() > 1 ? gotAddr[1] : 32'hDEADBEEF, 32'h000);
      checkOutput("wrap addr2", gotAddr.size() > 2 ? gotAddr[2] : 32'hDEADBEEF, 32'h004);

      // Zero-length job
      jobQ.delete();
      applyStimulus(12'h123, 100, 100, 0, "count0");

      // Randomized jobs
      for (int j = 0; j < 20; j++) begin
         jobQ.delete();
         repeat ($urandom_range(1, 8)) jobQ.push_back(randBundle());
         applyStimulus(12'($urandom), int'($urandom_range(50, 100)), int'($urandom_range(30, 100)), 0,
                       $sformatf("rand%0d", j));
      end

      // Reset mid-LOAD with one word queued
      i_base_addr = 12'h300; i_count = 10'd4; i_start = 1'b1; i_valid = 1'b1; i_mem_ready = 1'b0;
      i_opcode = 7'h13; i_rd_addr = 5'd1; i_rs1_addr = 5'd0; i_funct3 = 3'd0; i_imm = 32'd5;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      checkOutput("rst queued we", 32'(o_mem_we), 32'd1);
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      checkAllZero("midrst");
      i_rst = 1'b0; i_mem_ready = 1'b1; i_valid = 1'b1;
      repeat (6) begin
         @(negedge i_clk);
         checkOutput("midrst no write", 32'(o_mem_we), 32'd0);
         checkOutput("midrst idle", 32'(o_busy), 32'd0);
         @(posedge i_clk); #1;
      end
      i_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/rv32i_inst_encoder.md
Name: rv32i_inst_encoder

Overview:
- Inverse of the RV32I instruction decoder: accepts decoded instruction fields (opcode, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake and packs them into 32-bit RV32I words.
- Writes a programmed number of words to consecutive instruction-memory addresses through a back-pressured write port.
- Used by the self-test and boot loader to build programs in IMEM.

Parameters:
- ADDR_WIDTH, 12, IMEM byte-address width; addresses wrap modulo 2^ADDR_WIDTH.
- COUNT_WIDTH, 10, width of the instruction-count input.
- FIFO_DEPTH, 2, output FIFO entries between the encoder and the memory port (power of 2, ≥2).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_base_addr  in  ADDR_WIDTH  first write address (word aligned; bits[1:0] ignored)
- i_count  in  COUNT_WIDTH  number of instructions to write
- i_valid  in  1  field bundle valid
- o_ready  out  1  encoder can accept a bundle
- i_opcode  in  7  opcode
- i_rd_addr  in  5  rd field
- i_rs1_addr  in  5  rs1 field
- i_rs2_addr  in  5  rs2 field
- i_funct3  in  3  funct3 field
- i_funct7  in  7  funct7 field
- i_imm  in  32  full sign-extended immediate, as the decoder produces it
- o_mem_we  out  1  write request
- o_mem_addr  out  ADDR_WIDTH  write address
- o_mem_wdata  out  32  encoded word
- i_mem_ready  in  1  memory accepts the write this cycle
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse when the last word is written
- o_err  out  1  sticky error flag; cleared by i_start or i_rst

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; counters 0. Reset mid-operation flushes the FIFO and writes nothing further.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE → LOAD on i_start: latch the address from i_base_addr; clear o_err and the accepted/written counters. If i_count==0, go directly to DONE instead.
  - i_start outside IDLE is ignored.
  - LOAD → DRAIN when accepted count == i_count.
  - DRAIN → DONE when written count == i_count.
  - DONE asserts o_done for one cycle → IDLE.
- o_ready = (state==LOAD) && (FIFO occupancy < FIFO_DEPTH) && (accepted < count).
  - Registered-state function only; no combinational path from i_mem_ready or i_valid.
  - The accept condition i_valid && o_ready, not i_valid alone, advances the accepted count.
- Latency: bundle accepted in cycle N → word at the FIFO head and on o_mem_* in N+1 if the FIFO was empty. Sustained throughput is 1 word/cycle with i_mem_ready held high.
- Memory port: o_mem_we = FIFO not empty. A write completes on o_mem_we && i_mem_ready. o_mem_addr/o_mem_wdata stay stable while stalled. Each completed write increments the address by 4, wrapping modulo 2^ADDR_WIDTH.
- A simultaneous FIFO push and pop leaves occupancy unchanged.
- Encoding rules:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I (ITYPE, LOAD, JALR, SYSTEM, FENCE): imm[11:0]|rs1|f3|rd|op. For ITYPE with f3 = SLL or SRL/SRA: funct7|imm[4:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U (LUI, AUIPC): imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - Fields irrelevant to a format are ignored.
- Unknown opcode: write NOP 0x00000013 and set o_err. This applies whether or not the optional feature is compiled in.

Optional Feature:
- Macro RV32I_ENC_RANGE_CHECK_EN.
- Defined: illegal immediates write NOP 0x00000013 and set o_err. The write still consumes an address and counts toward i_count. Illegal immediates are:
  - I/S: imm[31:11] not all equal.
  - shift: imm[31:5] ≠ 0.
  - B: not a 13-bit signed value, or imm[0] = 1.
  - J: not a 21-bit signed value, or imm[0] = 1.
  - U: imm[11:0] ≠ 0.
- Undefined: immediates are truncated silently; only unknown opcodes set o_err.

Decomposition:
- Opcode/funct3 constants come from the shared decoder header.
- Add to the same header: an instruction-format enum (FMT_R, FMT_I, FMT_SHIFT, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD) and `NOP_INST` = 32'h00000013.
- One sub-module: rv32i_enc_fifo, a synchronous FIFO of FIFO_DEPTH×32-bit data with push/pop/full/empty/occupancy.

Test Plan:
- ADDI x1,x0,5 (op 0x13, rd 1, imm 5), base 0x100, count 1 → single write addr 0x100, data 0x00500093; o_done pulses one cycle after the write.
- SUB x3,x1,x2 then BEQ x1,x2,-4, count 2, i_mem_ready=1 → data 0x402081B3 @base, 0xFE208EE3 @base+4, back-to-back cycles.
- JAL x1,+2048 with i_mem_ready held low 5 cycles → o_mem_we/addr/data (0x001000EF) held stable; o_ready drops after FIFO_DEPTH accepts; write completes when ready rises.
- ADDR_WIDTH=12, base 0xFFC, count 3 → writes at 0xFFC, 0x000, 0x004.
- With RV32I_ENC_RANGE_CHECK_EN: BEQ imm=3, then LUI imm=0x12345001 → both write 0x00000013, o_err=1 and held until the next i_start; opcode 0x7F → NOP and o_err in both builds.
- i_count=0 → o_done pulses without any write. Separately, i_rst asserted mid-LOAD with 1 word queued → no further o_mem_we, all outputs 0 next cycle, FSM IDLE.
